// File: rtl/norm_sum_link.sv
// Cross-core sum exchange: serializes the local norm sum to the peer and deserializes the peer sum.
// Optional SUM_XCHG_PARITY_EN appends one parity beat per frame and flags bad frames in parity_err.
module norm_sum_link #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int sw      = bw_psum+4,
  parameter int lw      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [sw-1:0] local_sum,
  input  logic          local_sum_valid,
  output logic [sw-1:0] sum_in,
  output logic          sum_in_valid,
  output logic [lw-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [lw-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          tx_busy,
  output logic          parity_err
);
  localparam int NB = sw/lw;
`ifdef SUM_XCHG_PARITY_EN
  localparam int NBT = NB+1;
`else
  localparam int NBT = NB;
`endif
  localparam int FW = NBT*lw;
  localparam int CW = $clog2(NBT+1);
  localparam logic [CW-1:0] LAST = CW'(NBT-1);

  localparam logic [0:0] T_IDLE    = 1'b0;
  localparam logic [0:0] T_SEND    = 1'b1;
  localparam logic [0:0] R_COLLECT = 1'b0;
  localparam logic [0:0] R_HOLD    = 1'b1;

  logic [0:0]    t_state_q, t_state_d, r_state_q, r_state_d;
  logic [FW-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          local_seen_q, local_seen_d;
  logic [sw-1:0] sum_in_q, sum_in_d;
  logic          sum_in_valid_q, sum_in_valid_d;
  logic          rx_ready_q, rx_ready_d;
  logic          parity_err_q, parity_err_d;

  logic [FW-1:0] tx_frame, rx_shift;
  logic          par_ok;

  assign rx_shift = {rx_data, rx_sr_q[FW-1:lw]};

`ifdef SUM_XCHG_PARITY_EN
  assign tx_frame = {{(lw-1){1'b0}}, ^local_sum, local_sum};
  assign par_ok   = (rx_shift[sw] == ^rx_shift[sw-1:0]);
`else
  assign tx_frame = local_sum;
  assign par_ok   = 1'b1;
`endif

  always_comb begin
    t_state_d      = t_state_q;
    tx_sr_d        = tx_sr_q;
    tx_cnt_d       = tx_cnt_q;
    r_state_d      = r_state_q;
    rx_sr_d        = rx_sr_q;
    rx_cnt_d       = rx_cnt_q;
    local_seen_d   = local_seen_q;
    sum_in_d       = sum_in_q;
    sum_in_valid_d = 1'b0;
    parity_err_d   = parity_err_q;

    case (t_state_q)
      T_IDLE: if (local_sum_valid) begin
        tx_sr_d      = tx_frame;
        local_seen_d = 1'b1;
        t_state_d    = T_SEND;
      end
      default: if (tx_ready) begin
        tx_sr_d = tx_sr_q >> lw;
        if (tx_cnt_q == LAST) begin
          tx_cnt_d  = '0;
          t_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase

    // RX runs after TX so a delivery consuming this cycle's local pulse wins over its set of local_seen
    case (r_state_q)
      R_COLLECT: if (rx_valid && rx_ready_q) begin
        rx_sr_d = rx_shift;
        if (rx_cnt_q == LAST) begin
          rx_cnt_d = '0;
          if (!par_ok) begin
            parity_err_d = 1'b1;
          end else if (local_seen_q || local_sum_valid) begin
            sum_in_d       = rx_shift[sw-1:0];
            sum_in_valid_d = 1'b1;
            local_seen_d   = 1'b0;
          end else begin
            r_state_d = R_HOLD;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: if (local_seen_q || local_sum_valid) begin
        sum_in_d       = rx_sr_q[sw-1:0];
        sum_in_valid_d = 1'b1;
        local_seen_d   = 1'b0;
        r_state_d      = R_COLLECT;
      end
    endcase

    rx_ready_d = (r_state_d == R_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_state_q      <= T_IDLE;
      tx_sr_q        <= '0;
      tx_cnt_q       <= '0;
      r_state_q      <= R_COLLECT;
      rx_sr_q        <= '0;
      rx_cnt_q       <= '0;
      local_seen_q   <= 1'b0;
      sum_in_q       <= '0;
      sum_in_valid_q <= 1'b0;
      rx_ready_q     <= 1'b0;
      parity_err_q   <= 1'b0;
    end else begin
      t_state_q      <= t_state_d;
      tx_sr_q        <= tx_sr_d;
      tx_cnt_q       <= tx_cnt_d;
      r_state_q      <= r_state_d;
      rx_sr_q        <= rx_sr_d;
      rx_cnt_q       <= rx_cnt_d;
      local_seen_q   <= local_seen_d;
      sum_in_q       <= sum_in_d;
      sum_in_valid_q <= sum_in_valid_d;
      rx_ready_q     <= rx_ready_d;
      parity_err_q   <= parity_err_d;
    end
  end

  assign tx_data      = tx_sr_q[lw-1:0];
  assign tx_valid     = (t_state_q == T_SEND);
  assign tx_busy      = (t_state_q == T_SEND);
  assign rx_ready     = rx_ready_q;
  assign sum_in       = sum_in_q;
  assign sum_in_valid = sum_in_valid_q;
  assign parity_err   = parity_err_q;
endmodule

// File: doc/norm_sum_link.md
Name: norm_sum_link

Overview:
- Cross-core sum-exchange link for the normalization stage.
- Takes the local absolute-sum pulse from the local norm block and serializes it to the peer core over a narrow valid/ready link.
- Deserializes the peer core's sum and delivers it to the local norm block as a single-cycle sum_in/sum_in_valid pulse.
- Sits between the local norm block and the inter-core wires; it is both the transmitter and the receiver of the sum-exchange protocol.

Parameters:
- bw, 8, activation bit width
- bw_psum, 2*bw+4, psum width
- sw, bw_psum+4, exchanged sum width (24 at defaults)
- lw, 4, link data width per beat; sw must be divisible by lw

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- local_sum  in  sw  local signed sum from norm sum_out
- local_sum_valid  in  1  local sum valid (norm sum_out_valid)
- sum_in  out  sw  peer sum to norm sum_in
- sum_in_valid  out  1  one-cycle delivery pulse to norm sum_in_valid
- tx_data  out  lw  serialized beat to peer
- tx_valid  out  1  beat valid
- tx_ready  in  1  peer accepts beat
- rx_data  in  lw  beat from peer
- rx_valid  in  1  peer beat valid
- rx_ready  out  1  this block accepts beat
- tx_busy  out  1  TX frame in progress
- parity_err  out  1  sticky frame-check error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state is cleared at the clk edge where reset=1.
- Reset values:
  - sum_in=0, sum_in_valid=0, tx_data=0, tx_valid=0, tx_busy=0, parity_err=0.
  - rx_ready=0 while reset is high; rx_ready=1 in the first cycle after reset.
  - Both FSMs return to idle/collect, beat counters=0, local_seen=0.
- Beats per frame: NB = sw/lw (6 at defaults). Order is LSB-first: beat k carries bits [k*lw+lw-1 : k*lw].
- TX FSM, states T_IDLE and T_SEND:
  - T_IDLE: local_sum_valid=1 captures local_sum into the TX shift register, sets local_seen=1, moves to T_SEND.
  - tx_valid=1 and tx_busy=1 from the next cycle. tx_data is always shift_reg[lw-1:0].
  - T_SEND: on each edge with tx_valid&tx_ready, shift right by lw and increment the beat count. tx_data is held stable while tx_ready=0.
  - After beat NB-1 is accepted: T_IDLE, tx_valid=0, tx_busy=0.
  - local_sum_valid during T_SEND is ignored; the frame in flight is unchanged and local_seen is unaffected.
- RX FSM, states R_COLLECT and R_HOLD:
  - R_COLLECT: rx_ready=1. On each rx_valid&rx_ready, shift rx_data into the top of the RX register and increment the beat count.
  - After beat NB-1 the frame is complete.
  - If local_seen=1, or local_sum_valid=1 in the same cycle: sum_in<=assembled value and sum_in_valid=1 for exactly the next cycle. Clear local_seen, stay in R_COLLECT.
  - Otherwise enter R_HOLD: rx_ready=0 (backpressure). sum_in_valid pulses one cycle after the first local_sum_valid, then clear local_seen and return to R_COLLECT.
- sum_in holds its value after the pulse until the next delivery.
- Latency: last rx beat accepted at edge N with local already seen -> sum_in_valid high during cycle N+1.
- Simultaneous events: local_sum_valid on the same edge as the last rx beat counts as seen, so the pulse occurs at N+1. TX and RX operate fully independently.
- Reset mid-frame: partial TX and RX frames are discarded, and counters and local_seen are cleared.
- Arithmetic: the sum passes through bit-exact with no sign handling. The beat counters are ceil(log2(NB+1)) bits and clear on frame end.

Optional Feature:
- Macro: SUM_XCHG_PARITY_EN.
- Enabled:
  - Each frame gets one extra beat after the data beats (NB+1 beats total).
  - Extra beat: bit0 = XOR of all sw data bits, upper bits 0.
  - RX recomputes the parity. On mismatch: set parity_err=1 (sticky until reset), no sum_in_valid, frame dropped, return to R_COLLECT; local_seen is retained.
- Disabled: NB data beats only; parity_err tied to 0.

Test Plan:
1. Reset, local_sum=24'h000123 pulse, tx_ready=1 -> tx_data beats 3,2,1,0,0,0 on consecutive cycles, then tx_valid=0. Peer sends 24'h000456 beats 6,5,4,0,0,0 -> sum_in=24'h000456, sum_in_valid high exactly one cycle after the last beat.
2. tx_ready=0 for 3 cycles after beat 2 -> tx_data and tx_valid held stable. Exactly 6 beats accepted; the frame decodes to the original sum at the peer.
3. Peer frame 24'hFFFFF0 completes before any local_sum_valid -> rx_ready=0, no pulse. local_sum_valid 5 cycles later -> sum_in_valid one cycle after it, sum_in=24'hFFFFF0, rx_ready back to 1.
4. local_sum_valid with 24'h0000AA, then again with 24'h0000BB during T_SEND -> transmitted frame is 24'h0000AA; second pulse ignored.
5. reset asserted after 3 rx beats, then full frame 24'h012345 -> sum_in=24'h012345, no stale bits.
6. With SUM_XCHG_PARITY_EN: a frame with a flipped parity bit -> parity_err=1, no sum_in_valid. The following good frame is delivered normally and parity_err stays 1.
